video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//   Raster timing source for the display path. Counts pixel/line positions and
//   emits registered hsync/vsync/de plus pixel coordinates. Sits directly upstream
//   of the pipe_buf delay stages: hsync/vsync/de are pipe_buf'd to match pixel
//   datapath latency, while hpos/vpos drive the pixel fetch/scaler logic.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch, pixels
//   H_SYNC    96   hsync pulse width, pixels
//   H_BP      48   horizontal back porch, pixels
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch, lines
//   V_SYNC    2    vsync pulse width, lines
//   V_BP      33   vertical back porch, lines
//   HS_POL    0    hsync active level (0 = active-low)
//   VS_POL    0    vsync active level (0 = active-low)
//   Derived: H_TOTAL=sum of H_*; V_TOTAL=sum of V_*;
//            HW=$clog2(H_TOTAL); VW=$clog2(V_TOTAL).
// PORTS
//   clk          in   1   pixel-domain clock
//   rst_n        in   1   asynchronous reset, active-low
//   ce           in   1   pixel clock enable; state advances only when 1
//   hpos         out  HW  horizontal position, 0..H_TOTAL-1
//   vpos         out  VW  vertical position, 0..V_TOTAL-1
//   de           out  1   1 when hpos<H_ACTIVE and vpos<V_ACTIVE
//   hsync        out  1   horizontal sync at HS_POL level during sync interval
//   vsync        out  1   vertical sync at VS_POL level during sync interval
//   line_start   out  1   1-cycle pulse when hpos==0 is first presented
//   frame_start  out  1   1-cycle pulse when (hpos,vpos)==(0,0) is first presented
// BEHAVIOUR
//   - Single clock domain. Only rst_n is asynchronous; release is assumed synchronised upstream.
//   - Reset: hpos=0, vpos=0, de=0, hsync=!HS_POL, vsync=!VS_POL, line_start=0,
//     frame_start=0. Internal counters are 0 and armed so the first ce=1 cycle after
//     reset loads position (0,0).
//   - All outputs are registered. hpos/vpos and de/hsync/vsync/pulses in any cycle
//     describe the same raster position. This is zero skew between fields; the
//     downstream pipe_buf delays them as a group.
//   - On ce=1: hpos increments. At hpos==H_TOTAL-1, hpos wraps to 0 and vpos
//     increments. At vpos==V_TOTAL-1 with hpos wrap, vpos wraps to 0.
//   - On ce=0: every output holds its value, except line_start and frame_start,
//     which are forced to 0. Each pulse is asserted for exactly one ce=1 cycle.
//   - Horizontal regions (by hpos): active [0,H_ACTIVE); FP [H_ACTIVE,+H_FP);
//     sync [H_ACTIVE+H_FP,+H_SYNC); BP up to H_TOTAL-1.
//   - Vertical regions follow the same order by vpos. vsync changes on line
//     boundaries only, i.e. on the cycle that presents hpos==0.
//   - Comparisons are on counter values; no region boundary spans a wrap.
//   - Any parameter set to 0 is illegal; an elaboration check stops the build.
//   - Mid-frame reset returns immediately to the reset values above. No partial
//     pulse is emitted, and the first ce=1 cycle after release presents (0,0) with
//     frame_start=1.
// TESTING
//   1. Reset, then ce=1 continuously -> first output cycle: hpos=0, vpos=0, de=1,
//      frame_start=1, line_start=1. Next cycle: hpos=1, both pulses=0.
//   2. Default params, ce=1 -> hsync low exactly for hpos 656..751 (96 cycles per
//      line); H_TOTAL=800 cycles between successive line_start pulses.
//   3. Full frame -> vsync low on lines 490..491; frame_start period
//      800*525=420000 cycles; de high for 640*480=307200 cycles per frame.
//   4. ce toggling 1,0,0,1 around hpos=799, vpos=524 -> outputs held while ce=0.
//      Wrap to (0,0) occurs only on the next ce=1, and frame_start is high for
//      exactly that one cycle.
//   5. Assert rst_n low at (hpos=300, vpos=200) mid-active -> outputs go to reset
//      values asynchronously. After release, frame restarts at (0,0); no stale de.
//   6. Small params (H 4/1/2/1, V 3/1/1/1, HS_POL=1) -> exhaustively check
//      hpos/vpos/de/hsync/vsync against a reference model for 3 frames.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source for the display path.
// Produces registered pixel coordinates together with de/hsync/vsync and
// line/frame start pulses. All fields in a given cycle describe the same
// raster position, so the downstream pipe_buf stages can delay them as a group.

module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    // Region boundaries, pre-sized to the counter widths. Every boundary lies
    // strictly below the total because each porch is at least one unit wide.
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    // A zero-width region would collapse the raster; refuse to build.
    generate
        if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_params
            $error("video_timing_gen: every timing parameter must be non-zero");
        end
    endgenerate

    // High from reset until the first enabled cycle, which must present (0,0)
    // rather than advancing past it.
    logic          armed;
    logic [HW-1:0] nxt_h;
    logic [VW-1:0] nxt_v;
    logic          nxt_de;
    logic          nxt_hs_act;
    logic          nxt_vs_act;

    // Next raster position and the region decodes for that position.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_h = hpos + HW'(1);
        nxt_v = vpos;
        if (armed) begin
            nxt_h = '0;
            nxt_v = '0;
        end else if (hpos == H_LAST) begin
            nxt_h = '0;
            nxt_v = (vpos == V_LAST) ? '0 : vpos + VW'(1);
        end
        nxt_de     = (nxt_h < H_ACT_END) && (nxt_v < V_ACT_END);
        nxt_hs_act = (nxt_h >= H_SYNC_BEG) && (nxt_h < H_SYNC_END);
        // nxt_v only moves together with nxt_h returning to 0, so vsync can
        // only change on the cycle that presents the start of a line.
        nxt_vs_act = (nxt_v >= V_SYNC_BEG) && (nxt_v < V_SYNC_END);
    end

    // Register position, region flags and start pulses; pulses last one enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst_n) begin
            armed       <= 1'b1;
            hpos        <= '0;
            vpos        <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            armed       <= 1'b0;
            hpos        <= nxt_h;
            vpos        <= nxt_v;
            de          <= nxt_de;
            hsync       <= nxt_hs_act ? HS_POL : ~HS_POL;
            vsync       <= nxt_vs_act ? VS_POL : ~VS_POL;
            line_start  <= (nxt_h == '0);
            frame_start <= (nxt_h == '0) && (nxt_v == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of video_timing_gen.
// Three instances: default timing (horizontal checks), short lines with the
// default vertical timing (frame-level checks in few cycles), and a tiny
// raster with active-high hsync compared cycle by cycle against a model.

module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce_d = 1'b0;
    logic ce_m = 1'b0;
    logic ce_s = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // default instance
    logic [9:0] d_hpos, d_vpos;
    logic d_de, d_hs, d_vs, d_ls, d_fs;
    // short lines, default vertical timing (H_TOTAL=8, V_TOTAL=525)
    logic [2:0] m_hpos;
    logic [9:0] m_vpos;
    logic m_de, m_hs, m_vs, m_ls, m_fs;
    // tiny raster (H_TOTAL=8, V_TOTAL=6), hsync active high
    logic [2:0] s_hpos, s_vpos;
    logic s_de, s_hs, s_vs, s_ls, s_fs;

    video_timing_gen u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce_d),
        .hpos(d_hpos), .vpos(d_vpos), .de(d_de), .hsync(d_hs), .vsync(d_vs),
        .line_start(d_ls), .frame_start(d_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
    ) u_mid (
        .clk(clk), .rst_n(rst_n), .ce(ce_m),
        .hpos(m_hpos), .vpos(m_vpos), .de(m_de), .hsync(m_hs), .vsync(m_vs),
        .line_start(m_ls), .frame_start(m_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .ce(ce_s),
        .hpos(s_hpos), .vpos(s_vpos), .de(s_de), .hsync(s_hs), .vsync(s_vs),
        .line_start(s_ls), .frame_start(s_fs)
    );

    // Advance one clock and sample just after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        ce_d = 1'b0;
        ce_m = 1'b0;
        ce_s = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ce_d = 1'b1;
        step();
        step();
        n_vec++;
        if ({d_hpos, d_vpos, d_de, d_hs, d_vs, d_ls, d_fs} !== {10'd0, 10'd0, 5'b01100}) begin
            n_err++;
            $display("FAIL reset_state: got h=%0d v=%0d de/hs/vs/ls/fs=%b%b%b%b%b want h=0 v=0 01100",
                     d_hpos, d_vpos, d_de, d_hs, d_vs, d_ls, d_fs);
        end
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({d_hpos, d_vpos, d_de, d_hs, d_vs, d_ls, d_fs} !== {10'd0, 10'd0, 5'b11111}) begin
            n_err++;
            $display("FAIL first_cycle: got h=%0d v=%0d de/hs/vs/ls/fs=%b%b%b%b%b want h=0 v=0 11111",
                     d_hpos, d_vpos, d_de, d_hs, d_vs, d_ls, d_fs);
        end
        step();
        n_vec++;
        if ({d_hpos, d_vpos, d_ls, d_fs} !== {10'd1, 10'd0, 2'b00}) begin
            n_err++;
            $display("FAIL second_cycle: got h=%0d v=%0d ls=%b fs=%b want h=1 v=0 ls=0 fs=0",
                     d_hpos, d_vpos, d_ls, d_fs);
        end
    endtask

    task automatic test_hsync_line;
        int guard;
        int period;
        int low;
        int first_low;
        int last_low;
        int de_cnt;
        int v0;
        guard = 0;
        while (d_ls !== 1'b1 && guard < 2000) begin
            step();
            guard++;
        end
        n_vec++;
        if (d_ls !== 1'b1 || d_hpos !== 10'd0) begin
            n_err++;
            $display("FAIL line_start_seen: got ls=%b h=%0d want ls=1 h=0", d_ls, d_hpos);
        end
        v0 = int'(d_vpos);
        period = 0;
        low = 0;
        first_low = -1;
        last_low = -1;
        de_cnt = 0;
        do begin
            if (d_hs == 1'b0) begin
                low++;
                if (first_low < 0) first_low = int'(d_hpos);
                last_low = int'(d_hpos);
            end
            if (d_de == 1'b1) de_cnt++;
            step();
            period++;
        end while (d_ls !== 1'b1 && period < 2000);
        n_vec++;
        if (period != 800) begin
            n_err++;
            $display("FAIL line_period: got %0d want 800", period);
        end
        n_vec++;
        if (low != 96) begin
            n_err++;
            $display("FAIL hsync_width: got %0d want 96", low);
        end
        n_vec++;
        if (first_low != 656 || last_low != 751) begin
            n_err++;
            $display("FAIL hsync_span: got %0d..%0d want 656..751", first_low, last_low);
        end
        n_vec++;
        if (de_cnt != 640) begin
            n_err++;
            $display("FAIL de_per_line: got %0d want 640", de_cnt);
        end
        n_vec++;
        if (int'(d_vpos) != v0 + 1) begin
            n_err++;
            $display("FAIL vpos_step: got %0d want %0d", d_vpos, v0 + 1);
        end
    endtask

    task automatic test_frame;
        int period;
        int de_cnt;
        int vlow;
        int first_v;
        int last_v;
        int vs_bad;
        logic prev_vs;
        apply_reset();
        ce_m = 1'b1;
        step();
        n_vec++;
        if ({m_hpos, m_vpos, m_fs} !== {3'd0, 10'd0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_frame_start: got h=%0d v=%0d fs=%b want 0 0 1", m_hpos, m_vpos, m_fs);
        end
        period = 0;
        de_cnt = 0;
        vlow = 0;
        first_v = -1;
        last_v = -1;
        vs_bad = 0;
        prev_vs = m_vs;
        do begin
            if (m_vs == 1'b0) begin
                vlow++;
                if (first_v < 0) first_v = int'(m_vpos);
                last_v = int'(m_vpos);
            end
            if (m_vs !== prev_vs && m_hpos !== 3'd0) vs_bad++;
            prev_vs = m_vs;
            if (m_de == 1'b1) de_cnt++;
            step();
            period++;
        end while (m_fs !== 1'b1 && period < 10000);
        n_vec++;
        if (period != 4200) begin
            n_err++;
            $display("FAIL frame_period: got %0d want 4200", period);
        end
        n_vec++;
        if (de_cnt != 1920) begin
            n_err++;
            $display("FAIL de_per_frame: got %0d want 1920", de_cnt);
        end
        n_vec++;
        if (vlow != 16 || first_v != 490 || last_v != 491) begin
            n_err++;
            $display("FAIL vsync_lines: got %0d cycles on lines %0d..%0d want 16 on 490..491",
                     vlow, first_v, last_v);
        end
        n_vec++;
        if (vs_bad != 0) begin
            n_err++;
            $display("FAIL vsync_mid_line: got %0d edges off hpos 0 want 0", vs_bad);
        end
        n_vec++;
        if ({m_hpos, m_vpos} !== {3'd0, 10'd0}) begin
            n_err++;
            $display("FAIL frame_wrap: got h=%0d v=%0d want 0 0", m_hpos, m_vpos);
        end
    endtask

    task automatic test_ce_hold;
        int guard;
        guard = 0;
        while (!(m_hpos == 3'd7 && m_vpos == 10'd524) && guard < 5000) begin
            step();
            guard++;
        end
        n_vec++;
        if ({m_hpos, m_vpos} !== {3'd7, 10'd524}) begin
            n_err++;
            $display("FAIL reach_last: got h=%0d v=%0d want 7 524", m_hpos, m_vpos);
        end
        ce_m = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if ({m_hpos, m_vpos, m_de, m_hs, m_vs, m_ls, m_fs} !== {3'd7, 10'd524, 5'b01100}) begin
                n_err++;
                $display("FAIL hold_%0d: got h=%0d v=%0d de/hs/vs/ls/fs=%b%b%b%b%b want 7 524 01100",
                         k, m_hpos, m_vpos, m_de, m_hs, m_vs, m_ls, m_fs);
            end
        end
        ce_m = 1'b1;
        step();
        n_vec++;
        if ({m_hpos, m_vpos, m_de, m_hs, m_vs, m_ls, m_fs} !== {3'd0, 10'd0, 5'b11111}) begin
            n_err++;
            $display("FAIL wrap_on_ce: got h=%0d v=%0d de/hs/vs/ls/fs=%b%b%b%b%b want 0 0 11111",
                     m_hpos, m_vpos, m_de, m_hs, m_vs, m_ls, m_fs);
        end
        ce_m = 1'b0;
        step();
        n_vec++;
        if ({m_hpos, m_vpos, m_de, m_ls, m_fs} !== {3'd0, 10'd0, 3'b100}) begin
            n_err++;
            $display("FAIL pulse_clear: got h=%0d v=%0d de=%b ls=%b fs=%b want 0 0 1 0 0",
                     m_hpos, m_vpos, m_de, m_ls, m_fs);
        end
        ce_m = 1'b1;
        step();
        n_vec++;
        if ({m_hpos, m_vpos, m_ls, m_fs} !== {3'd1, 10'd0, 2'b00}) begin
            n_err++;
            $display("FAIL resume: got h=%0d v=%0d ls=%b fs=%b want 1 0 0 0", m_hpos, m_vpos, m_ls, m_fs);
        end
    endtask

    task automatic test_midframe_reset;
        int guard;
        apply_reset();
        ce_d = 1'b1;
        guard = 0;
        while (d_hpos !== 10'd300 && guard < 1000) begin
            step();
            guard++;
        end
        n_vec++;
        if (d_hpos !== 10'd300 || d_de !== 1'b1) begin
            n_err++;
            $display("FAIL reach_300: got h=%0d de=%b want 300 1", d_hpos, d_de);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({d_hpos, d_vpos, d_de, d_hs, d_vs, d_ls, d_fs} !== {10'd0, 10'd0, 5'b01100}) begin
            n_err++;
            $display("FAIL async_reset: got h=%0d v=%0d de/hs/vs/ls/fs=%b%b%b%b%b want 0 0 01100",
                     d_hpos, d_vpos, d_de, d_hs, d_vs, d_ls, d_fs);
        end
        step();
        rst_n = 1'b1;
        ce_d = 1'b0;
        step();
        n_vec++;
        if ({d_hpos, d_vpos, d_de, d_ls, d_fs} !== {10'd0, 10'd0, 3'b000}) begin
            n_err++;
            $display("FAIL no_stale_de: got h=%0d v=%0d de=%b ls=%b fs=%b want 0 0 0 0 0",
                     d_hpos, d_vpos, d_de, d_ls, d_fs);
        end
        ce_d = 1'b1;
        step();
        n_vec++;
        if ({d_hpos, d_vpos, d_de, d_fs} !== {10'd0, 10'd0, 2'b11}) begin
            n_err++;
            $display("FAIL restart: got h=%0d v=%0d de=%b fs=%b want 0 0 1 1", d_hpos, d_vpos, d_de, d_fs);
        end
        ce_d = 1'b0;

        apply_reset();
        ce_m = 1'b1;
        guard = 0;
        while (!(m_vpos == 10'd200 && m_hpos == 3'd2) && guard < 3000) begin
            step();
            guard++;
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({m_hpos, m_vpos, m_de, m_ls, m_fs} !== {3'd0, 10'd0, 3'b000}) begin
            n_err++;
            $display("FAIL mid_async_reset: got h=%0d v=%0d de=%b ls=%b fs=%b want 0 0 0 0 0 (guard %0d)",
                     m_hpos, m_vpos, m_de, m_ls, m_fs, guard);
        end
        step();
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({m_hpos, m_vpos, m_de, m_ls, m_fs} !== {3'd0, 10'd0, 3'b111}) begin
            n_err++;
            $display("FAIL mid_restart: got h=%0d v=%0d de=%b ls=%b fs=%b want 0 0 1 1 1",
                     m_hpos, m_vpos, m_de, m_ls, m_fs);
        end
        ce_m = 1'b0;
    endtask

    task automatic test_small_model;
        bit started;
        bit c;
        int eh;
        int ev;
        logic [9:0] exp_v;
        logic [9:0] got_v;
        apply_reset();
        started = 1'b0;
        eh = 0;
        ev = 0;
        exp_v = {3'd0, 3'd0, 4'b0010};
        exp_v = {3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0} >> 1;
        // reset: hpos 0, vpos 0, de 0, hsync 0 (active-high idle), vsync 1, ls 0, fs 0
        n_vec++;
        if ({s_hpos, s_vpos, s_de, s_hs, s_vs, s_ls, s_fs} !== {3'd0, 3'd0, 5'b00100}) begin
            n_err++;
            $display("FAIL small_reset: got h=%0d v=%0d de/hs/vs/ls/fs=%b%b%b%b%b want 0 0 00100",
                     s_hpos, s_vpos, s_de, s_hs, s_vs, s_ls, s_fs);
        end
        exp_v = {3'd0, 3'd0, 4'b0010};
        for (int cyc = 0; cyc < 200; cyc++) begin
            c = ((cyc % 7) != 3);
            ce_s = c;
            step();
            if (c) begin
                if (!started) begin
                    eh = 0;
                    ev = 0;
                    started = 1'b1;
                end else if (eh == 7) begin
                    eh = 0;
                    ev = (ev == 5) ? 0 : ev + 1;
                end else begin
                    eh++;
                end
                exp_v[9:7] = 3'(eh);
                exp_v[6:4] = 3'(ev);
                exp_v[3]   = (eh < 4) && (ev < 3);
                exp_v[2]   = (eh == 5) || (eh == 6);
                exp_v[1]   = (ev != 4);
                exp_v[0]   = (eh == 0);
            end else begin
                exp_v[0] = 1'b0;
            end
            got_v = {s_hpos, s_vpos, s_de, s_hs, s_vs, s_ls};
            n_vec++;
            if (got_v !== exp_v || s_fs !== (exp_v[0] && eh == 0 && ev == 0)) begin
                n_err++;
                $display("FAIL small_cyc%0d: got h=%0d v=%0d de/hs/vs/ls/fs=%b%b%b%b%b want h=%0d v=%0d de/hs/vs/ls=%b%b%b%b",
                         cyc, s_hpos, s_vpos, s_de, s_hs, s_vs, s_ls, s_fs,
                         exp_v[9:7], exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
        ce_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hsync_line();
        ce_d = 1'b0;
        test_frame();
        test_ce_hold();
        test_midframe_reset();
        test_small_model();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
